// File: rtl/data_mem_responder_if.sv
// Request/acknowledge bus between an initiator and data_mem_responder.
interface data_mem_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/data_mem_responder.sv
// Small word memory answering req with a one-cycle ack; err flags out-of-range addresses.
// Define MEM_WAIT_EN to insert WAIT_CYCLES wait states before each response.
module data_mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_responder_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for req; request fields latched on acceptance
  // WAIT  | wait-state countdown (MEM_WAIT_EN builds only)
  // RESP  | memory access; ack/err/rdata registered on the edge leaving it

`ifdef MEM_WAIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_t;
`endif

  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("DEPTH must be in 1..2**ADDR_W");
  end
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 1..15");
  end

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic              accept;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack_q, err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

`ifdef MEM_WAIT_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  logic [3:0] cnt_q;
`endif

  assign in_range = ({1'b0, addr_q} < DEPTH_LIM);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          accept = 1'b1;
`ifdef MEM_WAIT_EN
          state_d = WAIT;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef MEM_WAIT_EN
      WAIT: begin
        // req is deliberately ignored here: a dropped req never aborts
        if (cnt_q == 4'd0) state_d = RESP;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MEM_WAIT_EN
      cnt_q   <= 4'd0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      if (accept) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
`ifdef MEM_WAIT_EN
      if (accept) cnt_q <= WAIT_LOAD;
      else if (state_q == WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
`endif
      if (state_q == RESP) begin
        ack_q <= 1'b1;
        err_q <= !in_range;
        if (we_q) begin
          if (in_range) mem[addr_q] <= wdata_q;
        end else begin
          rdata_q <= in_range ? mem[addr_q] : '0;
        end
      end
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder; directed vectors carry hand-computed responses.
module tb_data_mem_responder;

`ifdef MEM_WAIT_EN
  localparam int LAT = 2 + 2;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic       e_err;
    logic [7:0] e_rd;
    int         e_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  data_mem_responder_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  data_mem_responder #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: pops one expectation per ack
  initial begin
    exp_t ex;
    wait (reset === 1'b1);
    forever begin
      @(posedge clk); #1;
      if (bus.ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ack: ack=1 at cycle %0d, expected no ack", cyc);
        end else begin
          ex = exp_q.pop_front();
          chk("ack_err", 32'(bus.err), 32'(ex.e_err));
          chk("ack_rdata", 32'(bus.rdata), 32'(ex.e_rd));
          chk("ack_cycle", 32'(cyc), 32'(ex.e_cyc));
        end
      end else begin
        chk("err_without_ack", 32'(bus.err), 32'd0);
      end
    end
  end

  // mode 0: hold; 1: change addr/wdata after acceptance; 2: drop req after acceptance
  task automatic txn(input logic w, input logic [3:0] a, input logic [7:0] d, input int mode,
                     input logic e_err, input logic [7:0] e_rd);
    exp_t ex;
    int   n;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    ex.e_err = e_err; ex.e_rd = e_rd; ex.e_cyc = cyc + LAT;
    exp_q.push_back(ex);
    @(posedge clk); #1;
    if (mode == 1) begin bus.addr = 4'd4; bus.wdata = 8'h99; end
    if (mode == 2) bus.req = 1'b0;
    n = 1;
    while (bus.ack !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.ack !== 1'b1) begin
      tests++; fails++;
      $display("FAIL ack_timeout: ack=0 after %0d cycles, expected 1", n);
      exp_q.delete();
    end
  endtask

  task automatic idle();
    bus.req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    bus.req = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    do_reset();

    txn(1'b0, 4'd5, 8'h00, 0, 1'b0, 8'h00);
    idle();

    // out of range write then read, memory must stay clear
    txn(1'b1, 4'd13, 8'h77, 0, 1'b1, 8'h00);
    txn(1'b0, 4'd13, 8'h00, 0, 1'b1, 8'h00);
    for (int i = 0; i < 12; i++) txn(1'b0, 4'(i), 8'h00, 0, 1'b0, 8'h00);
    txn(1'b0, 4'd12, 8'h00, 0, 1'b1, 8'h00);
    txn(1'b0, 4'd15, 8'h00, 0, 1'b1, 8'h00);
    idle();

    txn(1'b1, 4'd3, 8'hA5, 0, 1'b0, 8'h00);
    txn(1'b0, 4'd3, 8'h00, 0, 1'b0, 8'hA5);
    idle();

    txn(1'b1, 4'd11, 8'h11, 0, 1'b0, 8'hA5);
    txn(1'b0, 4'd11, 8'h00, 0, 1'b0, 8'h11);
    idle();

    // inputs change after acceptance: only addr 2 may be written
    txn(1'b1, 4'd2, 8'h5A, 1, 1'b0, 8'h11);
    idle();
    txn(1'b0, 4'd2, 8'h00, 0, 1'b0, 8'h5A);
    txn(1'b0, 4'd4, 8'h00, 0, 1'b0, 8'h00);
    idle();

    txn(1'b0, 4'd3, 8'h00, 2, 1'b0, 8'hA5);
    repeat (3) idle();

    // reset right after acceptance aborts the write
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 4'd7; bus.wdata = 8'h3C;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_ack", 32'(bus.ack), 32'd0);
    reset = 1'b1;
    txn(1'b0, 4'd7, 8'h00, 0, 1'b0, 8'h00);
    txn(1'b0, 4'd3, 8'h00, 0, 1'b0, 8'h00);
    repeat (5) idle();

    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
